// File: rtl/xy_line_sequencer_if.sv
// Command channel into the XY line sequencer: one signed line segment per valid/ready transfer.
interface xy_line_sequencer_if #(
  parameter int STEP_W = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic signed [STEP_W-1:0] cmd_dx;
  logic signed [STEP_W-1:0] cmd_dy;
  logic                     cmd_pen;
  logic [31:0]              cmd_period;

  modport master (output cmd_valid, cmd_dx, cmd_dy, cmd_pen, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dx, cmd_dy, cmd_pen, cmd_period, output cmd_ready);
endinterface

// File: rtl/xy_line_sequencer.sv
// Two-axis Bresenham line sequencer with pen settle; optional abort input via XY_SEQ_ABORT_EN.
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// PEN_WAIT | servo moving, wait PEN_SETTLE_CYCLES
// PLAN     | one cycle, dir settled, decide whether any steps remain
// STEP_HI  | step pulse high for the axes stepping this major step
// STEP_LO  | rest of the step period
// DONE     | one-cycle completion strobe
module xy_line_sequencer #(
  parameter int STEP_W            = 16,
  parameter int PULSE_HIGH_CYCLES = 50,
  parameter int PEN_SETTLE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  xy_line_sequencer_if.slave cmd,
`ifdef XY_SEQ_ABORT_EN
  input  logic abort,
  output logic aborted,
`endif
  output logic step_x,
  output logic dir_x,
  output logic step_y,
  output logic dir_y,
  output logic pen_down,
  output logic busy,
  output logic done_pulse
);

  typedef enum logic [2:0] {S_IDLE, S_PEN_WAIT, S_PLAN, S_STEP_HI, S_STEP_LO, S_DONE} state_t;

  localparam logic [31:0] C_HI         = 32'(PULSE_HIGH_CYCLES);
  localparam logic [31:0] C_HI_LOAD    = 32'(PULSE_HIGH_CYCLES - 1);
  localparam logic [31:0] C_SETTLE     = 32'(PEN_SETTLE_CYCLES - 1);
  localparam logic [31:0] C_MIN_PERIOD = 32'(2 * PULSE_HIGH_CYCLES);

  state_t r_state, w_next;

  logic [31:0]              r_cnt, r_lo_load, w_period, w_lo_load;
  logic [STEP_W-1:0]        r_major, r_minor, r_rem;
  logic [STEP_W-1:0]        w_ax, w_ay, w_major, w_minor;
  logic signed [STEP_W:0]   r_err, w_e, w_err_next;
  logic                     r_x_major, r_step_minor, r_dir_x, r_dir_y, r_pen;
  logic                     w_accept, w_enter_hi, w_tc, w_abort, w_abort_hi;

  assign w_accept   = (r_state == S_IDLE) && cmd.cmd_valid;
  assign w_tc       = (r_cnt == 32'd0);
  assign w_enter_hi = (w_next == S_STEP_HI) && (r_state != S_STEP_HI);

  // Negating the most negative value wraps to 2^(STEP_W-1), which is the right unsigned magnitude.
  assign w_ax      = cmd.cmd_dx[STEP_W-1] ? -cmd.cmd_dx : cmd.cmd_dx;
  assign w_ay      = cmd.cmd_dy[STEP_W-1] ? -cmd.cmd_dy : cmd.cmd_dy;
  assign w_major   = (w_ax >= w_ay) ? w_ax : w_ay;
  assign w_minor   = (w_ax >= w_ay) ? w_ay : w_ax;
  assign w_period  = (cmd.cmd_period < C_MIN_PERIOD) ? C_MIN_PERIOD : cmd.cmd_period;
  assign w_lo_load = w_period - C_HI - 32'd1;

  assign w_e        = r_err - $signed({1'b0, r_minor});
  assign w_err_next = w_e[STEP_W] ? (w_e + $signed({1'b0, r_major})) : w_e;

`ifdef XY_SEQ_ABORT_EN
  logic r_abort_pend, r_aborted;
  assign w_abort    = abort;
  assign w_abort_hi = abort || r_abort_pend;
  assign aborted    = (r_state == S_DONE) && r_aborted;

  // An abort seen mid-pulse is remembered so the pulse still completes its full high time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_abort_pend <= (r_state == S_STEP_HI) && (w_next == S_STEP_HI) && w_abort_hi;
      if ((w_next == S_DONE) && (r_state != S_DONE)) r_aborted <= w_abort_hi;
      else if (r_state == S_DONE)                    r_aborted <= 1'b0;
    end
  end
`else
  assign w_abort    = 1'b0;
  assign w_abort_hi = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd.cmd_valid) w_next = (cmd.cmd_pen != r_pen) ? S_PEN_WAIT : S_PLAN;
      S_PEN_WAIT: if (w_abort) w_next = S_DONE; else if (w_tc) w_next = S_PLAN;
      S_PLAN:     w_next = (w_abort || (r_rem == '0)) ? S_DONE : S_STEP_HI;
      S_STEP_HI:  if (w_tc) w_next = w_abort_hi ? S_DONE : S_STEP_LO;
      S_STEP_LO:  if (w_abort) w_next = S_DONE;
                  else if (w_tc) w_next = (r_rem == '0) ? S_DONE : S_STEP_HI;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (r_state == S_IDLE);
    busy          = (r_state != S_IDLE);
    done_pulse    = (r_state == S_DONE);
    step_x        = (r_state == S_STEP_HI) && (r_x_major || r_step_minor);
    step_y        = (r_state == S_STEP_HI) && (!r_x_major || r_step_minor);
    dir_x         = r_dir_x;
    dir_y         = r_dir_y;
    pen_down      = r_pen;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_lo_load    <= '0;
      r_major      <= '0;
      r_minor      <= '0;
      r_rem        <= '0;
      r_err        <= '0;
      r_x_major    <= 1'b0;
      r_step_minor <= 1'b0;
      r_dir_x      <= 1'b0;
      r_dir_y      <= 1'b0;
      r_pen        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dir_x   <= !cmd.cmd_dx[STEP_W-1];
        r_dir_y   <= !cmd.cmd_dy[STEP_W-1];
        r_pen     <= cmd.cmd_pen;
        r_major   <= w_major;
        r_minor   <= w_minor;
        r_rem     <= w_major;
        r_x_major <= (w_ax >= w_ay);
        r_err     <= $signed({1'b0, w_major >> 1});
        r_lo_load <= w_lo_load;
      end
      if (w_accept)                                        r_cnt <= C_SETTLE;
      else if (w_enter_hi)                                 r_cnt <= C_HI_LOAD;
      else if ((r_state == S_STEP_HI) && (w_next == S_STEP_LO)) r_cnt <= r_lo_load;
      else if (!w_tc)                                      r_cnt <= r_cnt - 32'd1;
      if (w_enter_hi) begin
        r_rem        <= r_rem - 1'b1;
        r_err        <= w_err_next;
        r_step_minor <= w_e[STEP_W];
      end
    end
  end

endmodule

// File: tb/tb_xy_line_sequencer.sv
// Randomized bench for xy_line_sequencer: a per-cycle expected trace is built from the line rules and compared every cycle.
module tb_xy_line_sequencer;
  localparam int W  = 4;
  localparam int PH = 2;
  localparam int PS = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  xy_line_sequencer_if #(.STEP_W(W)) cmd_if ();
  logic step_x, dir_x, step_y, dir_y, pen_down, busy, done_pulse;
`ifdef XY_SEQ_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  xy_line_sequencer #(.STEP_W(W), .PULSE_HIGH_CYCLES(PH), .PEN_SETTLE_CYCLES(PS)) dut (
    .clock(clock), .reset(reset), .cmd(cmd_if),
`ifdef XY_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y),
    .pen_down(pen_down), .busy(busy), .done_pulse(done_pulse)
  );

  typedef struct packed {logic sx; logic sy; logic bsy; logic dn;} exp_t;
  exp_t q[$];
  exp_t cmp_e;
  logic m_dir_x = 1'b0, m_dir_y = 1'b0, m_pen = 1'b0;
  bit   was_idle;
  int   cyc = 0, acc_cyc = 0, acc_cnt = 0;
  int   n_tests = 0, n_fail = 0;
  int   x_rises = 0, y_rises = 0, done_cnt = 0, done_cyc = 0;
  int   x_last = 0, x_gap = 0, x_first = -1;
  logic p_sx = 1'b0, p_sy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Minor-axis steps after k major steps follow from err staying in [0, major):
  // n_k = ceil((k*minor - floor(major/2)) / major).
  function automatic void build(int dx, int dy, bit pen, longint period);
    int ax, ay, mj, mn, e0, prev, n;
    bit xmaj, ms;
    longint p;
    exp_t e;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    xmaj = (ax >= ay);
    mj = xmaj ? ax : ay;
    mn = xmaj ? ay : ax;
    e0 = mj / 2;
    p = (period < 2 * PH) ? 2 * PH : period;
    e = '{1'b0, 1'b0, 1'b1, 1'b0};
    if (pen != m_pen) for (int i = 0; i < PS; i++) q.push_back(e);
    q.push_back(e);
    prev = 0;
    for (int k = 1; k <= mj; k++) begin
      n = (k * mn - e0 + mj - 1) / mj;
      ms = (n > prev);
      prev = n;
      for (longint t = 0; t < p; t++) begin
        e.sx = (t < PH) && (xmaj || ms);
        e.sy = (t < PH) && (!xmaj || ms);
        q.push_back(e);
      end
    end
    q.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b1});
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dir_x = 1'b0;
      m_dir_y = 1'b0;
      m_pen   = 1'b0;
    end else begin
      cyc++;
      was_idle = (q.size() == 0);
      if (!was_idle) void'(q.pop_front());
      if (was_idle && cmd_if.cmd_valid) begin
        build(int'(cmd_if.cmd_dx), int'(cmd_if.cmd_dy), cmd_if.cmd_pen, longint'(cmd_if.cmd_period));
        m_dir_x = (cmd_if.cmd_dx >= 0);
        m_dir_y = (cmd_if.cmd_dy >= 0);
        m_pen   = cmd_if.cmd_pen;
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      cmp_e = (q.size() != 0) ? q[0] : exp_t'{1'b0, 1'b0, 1'b0, 1'b0};
      check("cycle {sx,sy,busy,done,ready,dx,dy,pen}",
            {56'd0, step_x, step_y, busy, done_pulse, cmd_if.cmd_ready, dir_x, dir_y, pen_down},
            {56'd0, cmp_e.sx, cmp_e.sy, cmp_e.bsy, cmp_e.dn, !cmp_e.bsy, m_dir_x, m_dir_y, m_pen});
    end
    if (step_x && !p_sx) begin
      x_rises++;
      x_gap  = cyc - x_last;
      x_last = cyc;
      if (x_first < acc_cyc) x_first = cyc;
    end
    if (step_y && !p_sy) y_rises++;
    if (done_pulse) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_sx = step_x;
    p_sy = step_y;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int dx, input int dy, input bit pen, input int period);
    int a0;
    a0 = acc_cnt;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dx     = W'(dx);
    cmd_if.cmd_dy     = W'(dy);
    cmd_if.cmd_pen    = pen;
    cmd_if.cmd_period = 32'(period);
    for (int i = 0; i < 2000 && acc_cnt == a0; i++) tick();
    if (acc_cnt == a0) check("accept_timeout", 64'd1, 64'd0);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && (q.size() != 0 || busy); i++) tick();
    if (i == 3000) check("idle_timeout", 64'd1, 64'd0);
  endtask

  int xr0, yr0, dn0;
  task automatic snap();
    xr0 = x_rises;
    yr0 = y_rises;
    dn0 = done_cnt;
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dx     = '0;
    cmd_if.cmd_dy     = '0;
    cmd_if.cmd_pen    = 1'b0;
    cmd_if.cmd_period = '0;

    // reset without any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_outputs {sx,sy,busy,done,ready,dx,dy,pen}",
          {56'd0, step_x, step_y, busy, done_pulse, cmd_if.cmd_ready, dir_x, dir_y, pen_down}, 64'h08);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // dx=4 dy=2 pen stays up, period 10
    snap();
    send(4, 2, 1'b0, 10);
    check("t2_model_len", q.size(), 42);
    wait_idle();
    check("t2_x_pulses", x_rises - xr0, 4);
    check("t2_y_pulses", y_rises - yr0, 2);
    check("t2_done", done_cnt - dn0, 1);
    check("t2_x_period", x_gap, 10);
    check("t2_last_to_done", done_cyc - x_last, 10);
    check("t2_accept_to_done", done_cyc - acc_cyc, 41);
    check("t2_dirs", {dir_x, dir_y}, 2'b11);

    // dx=-3 pen down: settle then step
    snap();
    send(-3, 0, 1'b1, 10);
    check("t3_model_len", q.size(), 37);
    check("t3_pen_after_accept", pen_down, 1);
    wait_idle();
    check("t3_first_rise", x_first - acc_cyc, 6);
    check("t3_x_pulses", x_rises - xr0, 3);
    check("t3_y_pulses", y_rises - yr0, 0);
    check("t3_dir_x", dir_x, 0);

    // zero-length move lifting the pen
    snap();
    send(0, 0, 1'b0, 10);
    check("t4_model_len", q.size(), 7);
    wait_idle();
    check("t4_accept_to_done", done_cyc - acc_cyc, 6);
    check("t4_pulses", (x_rises - xr0) + (y_rises - yr0), 0);
    check("t4_done", done_cnt - dn0, 1);
    check("t4_pen", pen_down, 0);

    // most negative dx, period clamped
    snap();
    send(-8, 7, 1'b0, 1);
    check("t5_model_len", q.size(), 34);
    wait_idle();
    check("t5_x_pulses", x_rises - xr0, 8);
    check("t5_y_pulses", y_rises - yr0, 7);
    check("t5_x_period", x_gap, 4);
    check("t5_dirs", {dir_x, dir_y}, 2'b01);

    // reset in the middle of the second pulse
    snap();
    send(4, 2, 1'b0, 10);
    for (int i = 0; i < 200 && x_rises < xr0 + 2; i++) @(negedge clock);
    #2;
    check("t6_mid_pulse", step_x, 1);
    reset = 1'b1;
    #1;
    check("t6_reset_outputs {sx,busy,ready}", {step_x, busy, cmd_if.cmd_ready}, 3'b001);
    @(posedge clock);
    #1 reset = 1'b0;
    snap();
    send(1, 1, 1'b0, 5);
    wait_idle();
    check("t6_x_pulses", x_rises - xr0, 1);
    check("t6_y_pulses", y_rises - yr0, 1);

    // command held valid through DONE
    snap();
    send(2, 1, 1'b1, 6);
    send(-1, 3, 1'b1, 4);
    check("b2b_accept_after_done", acc_cyc - done_cyc, 2);
    wait_idle();
    check("b2b_done", done_cnt - dn0, 2);

    for (int n = 0; n < 30; n++) begin
      send(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
